// File: rtl/matrix_mac.sv
// Square matrix multiply C = A x B over external synchronous-read memories, results saturated to DATA_W bits.
// Latency: N+2 cycles per result element (N fetch, 1 drain, 1 write); N*N*(N+2) cycles per full run.
// Backpressure: none; read data must return exactly one cycle after its address, mac_start ignored while busy.
module matrix_mac #(
    parameter int N      = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mac_start,
    output logic [3:0]        a_row,
    output logic [3:0]        a_col,
    input  logic [DATA_W-1:0] a_data,
    output logic [3:0]        b_row,
    output logic [3:0]        b_col,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_enable,
    output logic [1:0]        wr_matrix_select,
    output logic [3:0]        wr_row,
    output logic [3:0]        wr_col,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam int ACC_W = 2*DATA_W + 4;
    localparam logic [3:0] LAST = 4'(N-1);
    localparam logic [ACC_W-1:0] SAT = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, FINISH} state_t;

    state_t           state;
    logic [3:0]       i, j, k;
    logic             acc_en;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] acc_next;

    // Read data trails its address by one cycle, so acc_en is the FETCH flag delayed by one.
    assign prod     = ACC_W'(a_data) * ACC_W'(b_data);
    assign acc_next = acc + (acc_en ? prod : '0);

    assign a_row = i;
    assign a_col = k;
    assign b_row = k;
    assign b_col = j;
    assign wr_matrix_select = 2'd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc_en    <= 1'b0;
            acc       <= '0;
            wr_enable <= 1'b0;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mac_start) begin
                        state  <= FETCH;
                        busy   <= 1'b1;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        acc    <= '0;
                        acc_en <= 1'b0;
                        done   <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                FETCH: begin
                    acc_en <= 1'b1;
                    acc    <= acc_next;
                    if (k == LAST) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + 4'd1;
                    end
                end
                DRAIN: begin
                    // Last product lands here; present the saturated sum during WRITE.
                    acc_en    <= 1'b0;
                    acc       <= acc_next;
                    wr_enable <= 1'b1;
                    wr_row    <= i;
                    wr_col    <= j;
                    if (acc_next > SAT) begin
                        wr_data <= '1;
                        ovf     <= 1'b1;
                    end else begin
                        wr_data <= acc_next[DATA_W-1:0];
                    end
                    state <= WRITE;
                end
                WRITE: begin
                    wr_enable <= 1'b0;
                    acc       <= '0;
                    k         <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i     <= '0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            i     <= i + 4'd1;
                            state <= FETCH;
                        end
                    end else begin
                        j     <= j + 4'd1;
                        state <= FETCH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mac.sv
// Directed bench for matrix_mac: vector table of whole-matrix runs plus reset-abort and start-during-run sequences.
module tb_matrix_mac;

    localparam int N  = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mac_start;
    logic [3:0]    a_row, a_col, b_row, b_col;
    logic [DW-1:0] a_data, b_data;
    logic          wr_enable;
    logic [1:0]    wr_matrix_select;
    logic [3:0]    wr_row, wr_col;
    logic [DW-1:0] wr_data;
    logic          busy, done, ovf;

    matrix_mac #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .mac_start(mac_start),
        .a_row(a_row), .a_col(a_col), .a_data(a_data),
        .b_row(b_row), .b_col(b_col), .b_data(b_data),
        .wr_enable(wr_enable), .wr_matrix_select(wr_matrix_select),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data one cycle after address.
    logic [DW-1:0] mem_a [16][16];
    logic [DW-1:0] mem_b [16][16];
    always @(posedge clk) begin
        a_data <= mem_a[a_row][a_col];
        b_data <= mem_b[b_row][b_col];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]    cap_r[$];
    logic [3:0]    cap_c[$];
    logic [DW-1:0] cap_d[$];
    int            sel_bad = 0;
    always @(negedge clk) begin
        if (wr_enable) begin
            cap_r.push_back(wr_row);
            cap_c.push_back(wr_col);
            cap_d.push_back(wr_data);
            if (wr_matrix_select !== 2'd2) sel_bad++;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // kind: 0 identity, 1 all ones, 2 all 255, 3 r*10+c
    function automatic logic [DW-1:0] fill_val(input int kind, input int r, input int c);
        case (kind)
            0:       return (r == c) ? 8'd1 : 8'd0;
            1:       return 8'd1;
            2:       return 8'd255;
            default: return 8'(r*10 + c);
        endcase
    endfunction

    // Hand-derived C element: 0 -> r*10+c, 1 -> 10, 2 -> 255 (saturated), 3 -> 1
    function automatic int exp_val(input int kind, input int r, input int c);
        case (kind)
            0:       return r*10 + c;
            1:       return 10;
            2:       return 255;
            default: return 1;
        endcase
    endfunction

    task automatic load(input int ak, input int bk);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                mem_a[r][c] = (r < N && c < N) ? fill_val(ak, r, c) : '0;
                mem_b[r][c] = (r < N && c < N) ? fill_val(bk, r, c) : '0;
            end
        cap_r.delete();
        cap_c.delete();
        cap_d.delete();
        sel_bad = 0;
    endtask

    typedef struct {
        string name;
        int    a_kind;
        int    b_kind;
        int    exp_kind;
        int    exp_ovf;
        int    restart_at;
    } vec_t;

    // Start a run; returns at the negedge after the accepting edge with start_cyc set.
    task automatic kick(output int start_cyc);
        @(negedge clk);
        mac_start = 1'b1;
        @(negedge clk);
        mac_start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", busy, 1);
        check("done_cleared_on_start", done, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int st;
        int bad_data;
        int bad_addr;
        load(v.a_kind, v.b_kind);
        kick(st);
        while (!done && (cyc - st) < 2000) begin
            mac_start = ((cyc - st) == v.restart_at);
            @(negedge clk);
        end
        mac_start = 1'b0;
        check({v.name, "_done_cycles"}, cyc - st, 1200);
        check({v.name, "_write_count"}, cap_d.size(), N*N);
        bad_data = 0;
        bad_addr = 0;
        for (int e = 0; e < cap_d.size() && e < N*N; e++) begin
            if (cap_r[e] !== 4'(e / N) || cap_c[e] !== 4'(e % N)) bad_addr++;
            if (cap_d[e] !== 8'(exp_val(v.exp_kind, e / N, e % N))) begin
                if (bad_data == 0)
                    $display("FAIL %s_data[%0d][%0d]: got %0d, expected %0d", v.name,
                             e / N, e % N, cap_d[e], exp_val(v.exp_kind, e / N, e % N));
                bad_data++;
            end
        end
        check({v.name, "_data_errors"}, bad_data, 0);
        check({v.name, "_order_errors"}, bad_addr, 0);
        check({v.name, "_select_errors"}, sel_bad, 0);
        check({v.name, "_ovf"}, ovf, v.exp_ovf);
        repeat (3) @(negedge clk);
        check({v.name, "_done_held"}, done, 1);
        check({v.name, "_idle_busy"}, busy, 0);
        check({v.name, "_idle_addr"}, {a_row, a_col, b_row, b_col}, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int st;
        int n_before;
        vecs[0] = '{"ident",    0, 3, 0, 0, -1};
        vecs[1] = '{"ones",     1, 1, 1, 0, -1};
        vecs[2] = '{"sat255",   2, 2, 2, 1, -1};
        vecs[3] = '{"ovfclear", 1, 1, 1, 0, -1};
        vecs[4] = '{"onesxid",  1, 0, 3, 0, -1};
        vecs[5] = '{"restart",  1, 1, 1, 0, 300};

        reset = 1'b1;
        mac_start = 1'b0;
        load(1, 1);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_enable", wr_enable, 0);
        check("rst_ovf", ovf, 0);
        check("rst_sel", wr_matrix_select, 2);
        check("rst_addr", {a_row, a_col, b_row, b_col}, 0);
        check("rst_wr_fields", {wr_row, wr_col, wr_data}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", busy, 0);

        for (int t = 0; t < 6; t++) run_vec(vecs[t]);

        // Abort at cycle 500: 41 elements written by then (write of element e at cycle 12e+11).
        load(1, 1);
        kick(st);
        while ((cyc - st) < 500) @(negedge clk);
        check("abort_busy_before", busy, 1);
        n_before = cap_d.size();
        check("abort_writes_before", n_before, 41);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_enable", wr_enable, 0);
        check("abort_addr", {a_row, a_col, b_row, b_col}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_more_writes", cap_d.size(), n_before);
        check("abort_idle_busy", busy, 0);

        run_vec(vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matrix_mac.md
MATRIX_MAC -- requirements
Module: matrix_mac

Interface
REQ-001 The module SHALL have parameter N, default 10, giving the square matrix dimension (rows/cols 0..N-1, N<=15).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the element width (unsigned).
REQ-003 The module SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port mac_start, input, 1 bit: start request, sampled only in IDLE.
REQ-006 The module SHALL have ports a_row and a_col, outputs, 4 bits each: read address into matrix 0 (A).
REQ-007 The module SHALL have port a_data, input, DATA_W bits: A element returned one cycle after its address.
REQ-008 The module SHALL have ports b_row and b_col, outputs, 4 bits each: read address into matrix 1 (B).
REQ-009 The module SHALL have port b_data, input, DATA_W bits: B element returned one cycle after its address.
REQ-010 The module SHALL have port wr_enable, output, 1 bit: one-cycle result write strobe.
REQ-011 The module SHALL have port wr_matrix_select, output, 2 bits: constant 2 (result matrix C).
REQ-012 The module SHALL have ports wr_row and wr_col, outputs, 4 bits each; and port wr_data, output, DATA_W bits: result write address and data.
REQ-013 The module SHALL have ports busy, done and ovf, outputs, 1 bit each: computing, result complete, saturation occurred.

Function
REQ-014 The module SHALL compute C[i][j] = sum over k of A[i][k]*B[k][j], i, j, k = 0..N-1, in row-major order of (i,j).
REQ-015 The FSM SHALL have states IDLE, FETCH, DRAIN, WRITE and FINISH; reset state is IDLE.
REQ-016 The FSM in IDLE SHALL move to FETCH on mac_start=1, clearing i, j, k, the accumulator, done and ovf.
REQ-017 The FSM in FETCH SHALL drive a_row=i, a_col=k, b_row=k, b_col=j, increment k each cycle, and move to DRAIN after issuing k=N-1.
REQ-018 Accumulation SHALL add a_data*b_data one cycle after the matching address (including the cycle in DRAIN); the accumulator SHALL be 2*DATA_W+4 bits and SHALL never wrap.
REQ-019 The FSM in DRAIN SHALL perform the final accumulate and move to WRITE.
REQ-020 The FSM in WRITE SHALL assert wr_enable for exactly one cycle with wr_row=i, wr_col=j, and wr_data = min(acc, 2^DATA_W-1).
REQ-021 If acc exceeds 2^DATA_W-1, ovf SHALL be set and SHALL stay set until the next accepted mac_start or reset.
REQ-022 WRITE SHALL clear the accumulator and k, then advance j; at j=N-1, j SHALL wrap to 0 and i SHALL increment.
REQ-023 WRITE SHALL go to FINISH after (i,j)=(N-1,N-1), otherwise to FETCH.
REQ-024 Each element SHALL take N+2 cycles: N in FETCH, 1 in DRAIN and 1 in WRITE; a full run SHALL take N*N*(N+2) cycles, which is 1200 for N=10.
REQ-025 The FSM in FINISH SHALL set done=1 and return to IDLE; done SHALL then hold 1 until the next accepted mac_start or reset.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 mac_start SHALL be ignored while busy=1, with no restart and no effect on counters.
REQ-028 wr_enable SHALL be 0 in every state except WRITE; read addresses SHALL be 0 in IDLE.

Reset
REQ-029 On reset=1, all outputs SHALL go to 0 immediately (except wr_matrix_select=2), the FSM SHALL go to IDLE, and counters and the accumulator SHALL clear.
REQ-030 Reset asserted mid-run SHALL abort the computation with no further wr_enable pulses; the next mac_start SHALL restart at (0,0).

Verification
REQ-031 A = identity, B[r][c] = r*10+c, mac_start -> 100 writes with C[r][c] = r*10+c, ovf=0, done=1.
REQ-032 A and B all 1 -> every wr_data = 10; done rises 1200 cycles after mac_start is accepted; exactly 100 wr_enable pulses, row-major order.
REQ-033 A and B all 255 -> every wr_data = 255 (saturated), ovf=1; the next run with all-1 inputs -> ovf=0.
REQ-034 mac_start pulsed at cycle 300 of a run -> no restart, write sequence unchanged, done at cycle 1200.
REQ-035 Reset at cycle 500 -> busy=0, done=0, wr_enable=0 immediately; a new mac_start gives a complete correct 1200-cycle run.
